// File: rtl/mac_pipe_if.sv
// rtl/mac_pipe_if.sv - operand/result bundle for mac_pipe
//   master: drives mac_st, mac_en, hold, mode, trunc, data_a, data_b
//   slave : drives result, result_vld, busy, count, ovf
interface mac_pipe_if #(
  parameter int DW  = 8,
  parameter int AW  = 20,
  parameter int LEN = 16,
  parameter int CW  = $clog2(LEN + 1)
);
  logic          mac_st;
  logic          mac_en;
  logic          hold;
  logic          mode;
  logic [1:0]    trunc;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [AW-1:0] result;
  logic          result_vld;
  logic          busy;
  logic [CW-1:0] count;
  logic          ovf;

  modport master (
    output mac_st, mac_en, hold, mode, trunc, data_a, data_b,
    input  result, result_vld, busy, count, ovf
  );

  modport slave (
    input  mac_st, mac_en, hold, mode, trunc, data_a, data_b,
    output result, result_vld, busy, count, ovf
  );
endinterface

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage pipelined LEN-term multiply-accumulate unit
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mac_pipe_if.slave (start/enable/hold/mode/trunc/operands in;
//              result, result_vld, busy, count, ovf out)
//   MAC_SAT_EN defined: accumulator saturates instead of wrapping
module mac_pipe #(
  parameter int DW  = 8,
  parameter int AW  = 20,
  parameter int LEN = 16,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic         clk,
  input  logic         rst,
  mac_pipe_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t          state_q;
  logic [AW-1:0]   acc_q;
  logic [2*DW-1:0] p_q;
  logic            p_vld_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic            mode_q;
  logic [1:0]      trunc_q;
  logic [AW-1:0]   result_q;
  logic            result_vld_q;
  logic            busy_q;

  logic [2*DW-1:0]      p_d;
  logic [AW-1:0]        p_ext;
  logic [AW:0]          sum;
  logic                 ovf_add;
  logic [AW-1:0]        acc_d;
  logic [3:0]           sh;
  logic signed [AW-1:0] acc_s;
  logic [AW-1:0]        result_d;

  always_comb begin
    // Operands widened to 2*DW first so the low 2*DW bits are the exact product
    if (mode_q)
      p_d = {{DW{bus.data_a[DW-1]}}, bus.data_a} * {{DW{bus.data_b[DW-1]}}, bus.data_b};
    else
      p_d = {{DW{1'b0}}, bus.data_a} * {{DW{1'b0}}, bus.data_b};

    p_ext = {{(AW-2*DW){mode_q & p_q[2*DW-1]}}, p_q};

    // One guard bit: carry-out in unsigned mode, sign-disagreement in signed mode
    sum     = {mode_q & acc_q[AW-1], acc_q} + {mode_q & p_ext[AW-1], p_ext};
    ovf_add = mode_q ? (sum[AW] ^ sum[AW-1]) : sum[AW];

`ifdef MAC_SAT_EN
    if (ovf_add) begin
      if (mode_q)
        acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      else
        acc_d = {AW{1'b1}};
    end else begin
      acc_d = sum[AW-1:0];
    end
`else
    acc_d = sum[AW-1:0];
`endif

    case (trunc_q)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd2;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase

    acc_s = acc_q;
    if (mode_q)
      result_d = acc_s >>> sh;
    else
      result_d = acc_q >> sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      p_q          <= '0;
      p_vld_q      <= 1'b0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      mode_q       <= 1'b0;
      trunc_q      <= 2'd0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      if (!bus.hold) begin
        if (bus.mac_st) begin
          // Restart wins over accumulate and acceptance this cycle
          state_q <= RUN;
          acc_q   <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
          p_vld_q <= 1'b0;
          mode_q  <= bus.mode;
          trunc_q <= bus.trunc;
          busy_q  <= 1'b1;
        end else begin
          if (p_vld_q) begin
            acc_q <= acc_d;
            if (ovf_add)
              ovf_q <= 1'b1;
          end
          p_vld_q <= 1'b0;
          case (state_q)
            IDLE: busy_q <= 1'b0;  // drops one cycle after DONE, covering the pulse
            RUN: begin
              if (bus.mac_en) begin
                p_q     <= p_d;
                p_vld_q <= 1'b1;
                count_q <= count_q + 1'b1;
                if (count_q == LAST)
                  state_q <= DRAIN;
              end
            end
            DRAIN: state_q <= DONE;
            DONE: begin
              result_q     <= result_d;
              result_vld_q <= 1'b1;
              state_q      <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.result     = result_q;
  assign bus.result_vld = result_vld_q;
  assign bus.busy       = busy_q;
  assign bus.count      = count_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - directed self-checking bench for mac_pipe
module tb_mac_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_pipe_if #(.DW(8), .AW(20), .LEN(4)) if0 ();
  mac_pipe_if #(.DW(8), .AW(17), .LEN(4)) if1 ();

  mac_pipe #(.DW(8), .AW(20), .LEN(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mac_pipe #(.DW(8), .AW(17), .LEN(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int tcount = 0;
  int n_vld0 = 0;

  always @(negedge clk) if (if0.result_vld === 1'b1) n_vld0++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic start0(input logic m, input logic [1:0] t);
    if0.mac_st = 1'b1;
    if0.mode   = m;
    if0.trunc  = t;
    tick();
    if0.mac_st = 1'b0;
  endtask

  task automatic term0(input logic [7:0] a, input logic [7:0] b);
    if0.mac_en = 1'b1;
    if0.data_a = a;
    if0.data_b = b;
    tick();
    if0.mac_en = 1'b0;
  endtask

  task automatic wait_vld0(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (if0.result_vld === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int t0;
  int v0;

  initial begin
    rst = 1'b1;
    if0.mac_st = 0; if0.mac_en = 0; if0.hold = 0; if0.mode = 0; if0.trunc = 0;
    if0.data_a = 0; if0.data_b = 0;
    if1.mac_st = 0; if1.mac_en = 0; if1.hold = 0; if1.mode = 0; if1.trunc = 0;
    if1.data_a = 0; if1.data_b = 0;
    tick();
    tick();
    chk("rst_result", if0.result, 0);
    chk("rst_vld", if0.result_vld, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_count", if0.count, 0);
    chk("rst_ovf", if0.ovf, 0);
    rst = 1'b0;
    tick();

    // Signed accumulation: 15 - 14 - 16256 + 16384 = 129
    start0(1'b1, 2'd0);
    t0 = tcount;
    chk("s_busy_start", if0.busy, 1);
    chk("s_count_start", if0.count, 0);
    term0(8'd3, 8'd5);
    chk("s_count1", if0.count, 1);
    term0(8'hFE, 8'd7);
    term0(8'd127, 8'h80);
    term0(8'h80, 8'h80);
    chk("s_count4", if0.count, 4);
    wait_vld0(10, lat);
    chk("s_lat", lat, 2);
    chk("s_total", tcount - t0, 6);
    chk("s_result", if0.result, 129);
    chk("s_ovf", if0.ovf, 0);
    chk("s_busy_vld", if0.busy, 1);
    tick();
    chk("s_vld_pulse", if0.result_vld, 0);
    chk("s_busy_end", if0.busy, 0);
    chk("s_result_held", if0.result, 129);

    // Unsigned, trunc=1: 4*65025 = 260100 >> 2 = 65025
    start0(1'b0, 2'd1);
    for (int i = 0; i < 4; i++) term0(8'd255, 8'd255);
    wait_vld0(10, lat);
    chk("u_lat", lat, 2);
    chk("u_result", if0.result, 65025);
    chk("u_ovf", if0.ovf, 0);

    // Stall: three hold cycles after the second term, mac_en asserted during hold
    start0(1'b1, 2'd0);
    t0 = tcount;
    term0(8'd3, 8'd5);
    term0(8'hFE, 8'd7);
    if0.hold = 1'b1;
    if0.mac_en = 1'b1;
    if0.data_a = 8'd50;
    if0.data_b = 8'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_count_frozen", if0.count, 2);
    end
    if0.hold = 1'b0;
    if0.mac_en = 1'b0;
    term0(8'd127, 8'h80);
    term0(8'h80, 8'h80);
    wait_vld0(10, lat);
    chk("h_lat", lat, 2);
    chk("h_total", tcount - t0, 9);
    chk("h_result", if0.result, 129);

    // Overflow on the 17-bit instance: 4 * 16384 = 65536 exceeds signed max
    if1.mode = 1'b1;
    if1.trunc = 2'd0;
    if1.mac_st = 1'b1;
    tick();
    if1.mac_st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if1.mac_en = 1'b1;
      if1.data_a = 8'h80;
      if1.data_b = 8'h80;
      tick();
    end
    if1.mac_en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (if1.result_vld === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("o_lat", lat, 2);
`ifdef MAC_SAT_EN
    chk("o_result", if1.result, 32'h0FFFF);
`else
    chk("o_result", if1.result, 32'h10000);
`endif
    chk("o_ovf", if1.ovf, 1);
    tick();
    chk("o_ovf_sticky", if1.ovf, 1);

    // Restart mid-run; the concurrent mac_en term is discarded
    v0 = n_vld0;
    start0(1'b0, 2'd0);
    term0(8'd100, 8'd100);
    term0(8'd100, 8'd100);
    chk("r_count2", if0.count, 2);
    if0.mac_en = 1'b1;
    if0.data_a = 8'd100;
    if0.data_b = 8'd100;
    start0(1'b0, 2'd0);
    if0.mac_en = 1'b0;
    chk("r_count_restart", if0.count, 0);
    for (int i = 0; i < 4; i++) term0(8'd1, 8'd1);
    wait_vld0(10, lat);
    chk("r_lat", lat, 2);
    chk("r_result", if0.result, 4);
    chk("r_count_done", if0.count, 4);
    tick();
    tick();
    chk("r_vld_once", n_vld0 - v0, 1);

    // Reset after three terms aborts with everything cleared
    start0(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) term0(8'd5, 8'd5);
    v0 = n_vld0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("m_result", if0.result, 0);
    chk("m_vld", if0.result_vld, 0);
    chk("m_busy", if0.busy, 0);
    chk("m_count", if0.count, 0);
    chk("m_ovf", if0.ovf, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("m_no_vld", n_vld0 - v0, 0);
    chk("m_busy_idle", if0.busy, 0);

    // Fresh unsigned run, trunc=3: 4*40000 = 160000 >> 8 = 625
    start0(1'b0, 2'd3);
    for (int i = 0; i < 4; i++) term0(8'd200, 8'd200);
    wait_vld0(10, lat);
    chk("f_lat", lat, 2);
    chk("f_result", if0.result, 625);

    // Signed negative, trunc=2: 4*(-16256) = -65024 >>> 4 = -4064
    start0(1'b1, 2'd2);
    for (int i = 0; i < 4; i++) term0(8'h80, 8'd127);
    wait_vld0(10, lat);
    chk("n_lat", lat, 2);
    chk("n_result", if0.result, 32'hFF020);
    chk("n_ovf", if0.ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
